alu_exec_unit: RTL and testbench

//   Execute-stage ALU that consumes the 4-bit ALUop produced by the ALU decoder.

---
 rtl/alu_exec_unit_pkg.sv | 30 +++
 rtl/alu_exec_unit_comb_ops.sv | 33 +++
 rtl/alu_exec_unit.sv | 132 +++++++++++++
 tb/tb_alu_exec_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALUop codes, FSM state encoding and op-class helper for the execute-stage ALU.
// Used by both the ALU decoder and alu_exec_unit.
package alu_exec_unit_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [3:0] ALUOP_SLT  = 4'b0010;
  localparam logic [3:0] ALUOP_SLTU = 4'b0011;
  localparam logic [3:0] ALUOP_ADD  = 4'b0110;
  localparam logic [3:0] ALUOP_LUI  = 4'b0111;
  localparam logic [3:0] ALUOP_XOR  = 4'b1000;
  localparam logic [3:0] ALUOP_OR   = 4'b1001;
  localparam logic [3:0] ALUOP_AND  = 4'b1010;
  localparam logic [3:0] ALUOP_SLL  = 4'b1011;
  localparam logic [3:0] ALUOP_SRA  = 4'b1100;
  localparam logic [3:0] ALUOP_SRL  = 4'b1101;
  localparam logic [3:0] ALUOP_SUB  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALUOP_SLL) || (op == ALUOP_SRA) || (op == ALUOP_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb_ops.sv
// Single-cycle ALU datapath: add/sub, compares, logic ops, LUI and illegal-code decode.
// Shift codes are legal here but produce 0; the parent unit owns the shifter.
module alu_comb_ops
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_op)
      ALUOP_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALUOP_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      ALUOP_ADD:  o_result = i_a + i_b;
      ALUOP_SUB:  o_result = i_a - i_b;
      ALUOP_LUI:  o_result = i_b;
      ALUOP_XOR:  o_result = i_a ^ i_b;
      ALUOP_OR:   o_result = i_a | i_b;
      ALUOP_AND:  o_result = i_a & i_b;
      ALUOP_SLL, ALUOP_SRA, ALUOP_SRL: o_result = '0;
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides: 1-cycle ops, iterative 1-bit/cycle shifts.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a 1-cycle barrel shifter.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  state_e             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_illegal;

  logic               w_accept;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_comb_result;
  logic               w_comb_illegal;

  alu_comb_ops #(.WIDTH(WIDTH)) u_comb_ops (
    .i_op      (alu_op),
    .i_a       (op_a),
    .i_b       (op_b),
    .o_result  (w_comb_result),
    .o_illegal (w_comb_illegal)
  );

  // A finished result being drained frees the unit for a new op in the same cycle.
  assign in_ready   = ~rst & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
  assign w_accept   = in_valid & in_ready;
  assign w_is_shift = is_shift_op(alu_op);
  assign w_shamt    = op_b[SHAMT_W-1:0];

`ifdef ALU_BARREL_SHIFT_EN
  logic [WIDTH-1:0] w_barrel;

  always_comb begin
    w_barrel = op_a;
    case (alu_op)
      ALUOP_SLL: w_barrel = op_a << w_shamt;
      ALUOP_SRL: w_barrel = op_a >> w_shamt;
      ALUOP_SRA: w_barrel = $signed(op_a) >>> w_shamt;
      default:   w_barrel = op_a;
    endcase
  end
`else
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      r_cnt       <= '0;
      r_op        <= '0;
`endif
    end else if (w_accept) begin
      r_illegal <= w_comb_illegal;
      if (w_is_shift) begin
`ifdef ALU_BARREL_SHIFT_EN
        r_result    <= w_barrel;
        r_out_valid <= 1'b1;
        r_state     <= ST_DONE;
`else
        // r_result doubles as the shift register while the op is in flight.
        r_result <= op_a;
        r_op     <= alu_op;
        r_cnt    <= w_shamt;
        if (w_shamt == '0) begin
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end else begin
          r_out_valid <= 1'b0;
          r_state     <= ST_SHIFT;
        end
`endif
      end else begin
        r_result    <= w_comb_result;
        r_out_valid <= 1'b1;
        r_state     <= ST_DONE;
      end
    end else begin
      case (r_state)
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        ST_SHIFT: begin
          case (r_op)
            ALUOP_SLL: r_result <= {r_result[WIDTH-2:0], 1'b0};
            ALUOP_SRL: r_result <= {1'b0, r_result[WIDTH-1:1]};
            default:   r_result <= {r_result[WIDTH-1], r_result[WIDTH-1:1]};
          endcase
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus randomized ops and back-pressure.
// Expected results and latencies come from a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  bit   seen = 1'b0;
  bit   rnd_rdy = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the ALUop table.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill, output int lat);
    int amt;
    amt = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    r   = 32'h0;
    case (op)
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0110: r = a + b;
      4'b1110: r = a - b;
      4'b0111: r = b;
      4'b1000: r = a ^ b;
      4'b1001: r = a | b;
      4'b1010: r = a & b;
      4'b1011: r = a << amt;
      4'b1100: r = $signed(a) >>> amt;
      4'b1101: r = a >> amt;
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
`ifndef ALU_BARREL_SHIFT_EN
    if ((op == 4'b1011 || op == 4'b1100 || op == 4'b1101) && amt > 0) lat = amt + 1;
`endif
  endfunction

  task automatic push_exp();
    exp_t e;
    ref_model(alu_op, op_a, op_b, e.res, e.ill, e.lat);
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle_cycles(input int n);
    next_cycle();
    in_valid = 1'b0;
    for (int k = 1; k < n; k++) next_cycle();
  endtask

  // Offers an op until accepted; while stalled in random mode the offered values churn.
  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    next_cycle();
    alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
    for (int n = 0; n <= 100; n++) begin
      #4;
      if (in_ready) begin
        push_exp();
        break;
      end
      if (n == 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
      next_cycle();
      if (rnd_rdy) begin
        alu_op = 4'($urandom_range(0, 15)); op_a = $urandom; op_b = $urandom;
      end
    end
  endtask

  task automatic drain();
    next_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && q.size() != 0; n++) next_cycle();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_pulse(input string tag);
    next_cycle();
    #1 rst = 1'b1;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"}, result, 32'h0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
    q.delete();
    seen = 1'b0;
    in_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #4;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            if (!seen) begin
              check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
              seen = 1'b1;
            end
            check("result", result, q[0].res);
            check("illegal", 32'(illegal), 32'(q[0].ill));
            if (out_ready) begin
              void'(q.pop_front());
              seen = 1'b0;
            end
          end
        end else if (q.size() != 0) begin
          check("in_ready_while_busy", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'h0; op_a = 32'h0; op_b = 32'h0;
    #23;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    drive_op(4'b0110, 32'hFFFF_FFFF, 32'h1);
    drive_op(4'b0010, 32'hFFFF_FFFE, 32'h1);
    drive_op(4'b0011, 32'hFFFF_FFFE, 32'h1);
    drive_op(4'b1100, 32'h8000_0000, 32'h4);
    drive_op(4'b1101, 32'h1234_5678, 32'h0);
    drive_op(4'b1011, 32'h0000_0003, 32'h1F);
    drive_op(4'b1111, 32'hDEAD_BEEF, 32'h5);
    drive_op(4'b0111, 32'h1111_1111, 32'hABCD_E000);

    // Back-pressure: SUB result must hold while out_ready is low, then hand off same cycle.
    drive_op(4'b1110, 32'd5, 32'd7);
    next_cycle();
    out_ready = 1'b0;
    alu_op = 4'b0110; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      next_cycle();
    end
    out_ready = 1'b1;
    #4;
    check("release_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) push_exp();
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      drive_op(4'($urandom_range(0, 15)), pick(), pick());
    end
    rnd_rdy = 1'b0;
    drain();

    drive_op(4'b1011, 32'h1, 32'd20);
    idle_cycles(2);
    reset_pulse("rst_mid_shift");

    drive_op(4'b0110, 32'd1, 32'd2);
    next_cycle();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    next_cycle();
    reset_pulse("rst_in_done");
    out_ready = 1'b1;

    drive_op(4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
